// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    // Number of shift-add / restore-subtract iterations per operation.
    localparam int unsigned MDU_ITERS = 32;

    // Operation codes as presented on op_i.
    typedef enum logic [1:0] {
        MDU_OP_MUL   = 2'b00,
        MDU_OP_MULHU = 2'b01,
        MDU_OP_DIVU  = 2'b10,
        MDU_OP_REMU  = 2'b11
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: acc holds {partial product high, remaining multiplier bits}.
// Divide:   acc[XLEN-1:0] holds {remaining dividend bits, quotient bits}.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_ITERS
) (
    input  mdu_op_e             op_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN:0]       rem_i,
    input  logic [XLEN-1:0]     divisor_i,
    output logic [2*XLEN-1:0]   acc_o,
    output logic [XLEN:0]       rem_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Shift-add for MUL/MULHU, restoring subtract for DIVU/REMU.
    always_comb begin
        acc_o   = acc_i;
        rem_o   = rem_i;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (op_i == MDU_OP_DIVU || op_i == MDU_OP_REMU) begin
            shifted = {rem_i[XLEN-1:0], acc_i[XLEN-1]};
            diff    = shifted - {1'b0, divisor_i};
            if (shifted >= {1'b0, divisor_i}) begin
                rem_o = diff;
                acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b1};
            end else begin
                rem_o = shifted;
                acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, divisor_i} : '0);
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with register-file writeback.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN       = MDU_ITERS,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  busy_o,
    output logic [REG_ADDR_W-1:0] wR_o,
    output logic [XLEN-1:0]       wD_o,
    output logic                  WE_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    mdu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mdu_op_e               op_q, op_d;
    logic [XLEN-1:0]       divisor_q, divisor_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN:0]         rem_q, rem_d;
    logic [REG_ADDR_W-1:0] wr_q, wr_d;
    logic [XLEN-1:0]       wd_q, wd_d;
    logic                  we_q, we_d;

    logic [2*XLEN-1:0]     step_acc;
    logic [XLEN:0]         step_rem;
    logic [XLEN-1:0]       result;
    logic                  accept;

    mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .acc_o     (step_acc),
        .rem_o     (step_rem)
    );

    // Select the final result word from the last iteration's outputs.
    always_comb begin
        result = '0;
        case (op_q)
            MDU_OP_MUL:   result = step_acc[XLEN-1:0];
            MDU_OP_MULHU: result = step_acc[2*XLEN-1:XLEN];
            MDU_OP_DIVU:  result = step_acc[XLEN-1:0];
            MDU_OP_REMU:  result = step_rem[XLEN-1:0];
        endcase
    end

    // Next-state, iteration and writeback logic.
    // A start seen in DONE is accepted on the edge that leaves DONE, so a
    // back-to-back request begins at E33 without an idle bubble.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        wr_d      = wr_q;
        wd_d      = wd_q;
        we_d      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                accept = start_i;
            end
            MDU_CALC: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = MDU_DONE;
                    wd_d    = result;
                    wr_d    = rd_q;
                    we_d    = (rd_q != '0);
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                accept  = start_i;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        if (accept) begin
            state_d   = MDU_CALC;
            cnt_d     = '0;
            op_d      = mdu_op_e'(op_i);
            divisor_d = rs2_i;
            rd_d      = rd_i;
            acc_d     = {{XLEN{1'b0}}, rs1_i};
            rem_d     = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_OP_MUL;
            divisor_q <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            wr_q      <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            divisor_q <= divisor_d;
            rd_q      <= rd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
            we_q      <= we_d;
        end
    end

    assign busy_o = (state_q != MDU_IDLE);
    assign wR_o   = wr_q;
    assign wD_o   = wd_q;
    assign WE_o   = we_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus multi-cycle sequences.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        busy_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;
    logic        WE_o;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .rd_i    (rd_i),
        .busy_o  (busy_o),
        .wR_o    (wR_o),
        .wD_o    (wD_o),
        .WE_o    (WE_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issues one request (accepted at E0) and observes 40 cycles after it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int we_cnt, output int we_first,
                          output int busy_cnt, output logic [31:0] wd_at_we);
        we_cnt   = 0;
        we_first = -1;
        busy_cnt = 0;
        wd_at_we = 'x;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
        @(negedge clk_i);
        start_i = 1'b0;
        rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_0003;
        for (int k = 0; k < 40; k++) begin
            if (busy_o) busy_cnt++;
            if (WE_o) begin
                if (we_cnt == 0) begin
                    we_first = k;
                    wd_at_we = wD_o;
                end
                we_cnt++;
            end
            if (k < 39) @(negedge clk_i);
        end
    endtask

    initial begin
        int          we_cnt, we_first, busy_cnt, we_second;
        logic [31:0] wd_at_we;
        logic [31:0] wd_second;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
        vecs[3]  = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd14};
        vecs[4]  = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2};
        vecs[5]  = '{2'b10, 32'h0000_1234,  32'd0,          5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{2'b11, 32'h0000_1234,  32'd0,          5'd7,  32'h0000_1234};
        vecs[7]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  5'd8,  32'h0000_0000};
        vecs[8]  = '{2'b01, 32'h0001_0000,  32'h0001_0000,  5'd9,  32'h0000_0001};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF};
        vecs[10] = '{2'b11, 32'd5,          32'd9,          5'd10, 32'd5};

        reset_i = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_we",   {31'd0, WE_o},   32'd0);
        check("reset_wd",   wD_o,            32'd0);
        check("reset_wr",   {27'd0, wR_o},   32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, we_cnt, we_first, busy_cnt, wd_at_we);
            check($sformatf("vec%0d_wd", i),       wd_at_we,              vecs[i].exp);
            check($sformatf("vec%0d_wd_hold", i),  wD_o,                  vecs[i].exp);
            check($sformatf("vec%0d_wr", i),       {27'd0, wR_o},         {27'd0, vecs[i].rd});
            check($sformatf("vec%0d_we_cnt", i),   we_cnt,                32'd1);
            check($sformatf("vec%0d_we_cycle", i), we_first,              32'd32);
            check($sformatf("vec%0d_busy", i),     busy_cnt,              32'd33);
        end

        // rd = 0: full latency, never writes.
        run_op(2'b00, 32'd3, 32'd3, 5'd0, we_cnt, we_first, busy_cnt, wd_at_we);
        check("rd0_we_cnt", we_cnt,   32'd0);
        check("rd0_busy",   busy_cnt, 32'd33);

        // Starts at E5/E20 ignored (with junk operands), start at E33 accepted.
        we_cnt = 0; we_first = -1; we_second = -1; busy_cnt = 0; wd_at_we = 'x; wd_second = 'x;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd7; rs2_i = 32'd6; rd_i = 5'd5;
        @(negedge clk_i);
        for (int k = 0; k <= 70; k++) begin
            if (busy_o) busy_cnt++;
            if (WE_o) begin
                if (we_cnt == 0) begin
                    we_first = k; wd_at_we = wD_o;
                end else if (we_cnt == 1) begin
                    we_second = k; wd_second = wD_o;
                    check("b2b_wr2", {27'd0, wR_o}, 32'd9);
                end
                we_cnt++;
            end
            start_i = 1'b0;
            op_i = 2'b01; rs1_i = 32'h1111_1111; rs2_i = 32'h2222_2222; rd_i = 5'd17;
            if (k + 1 == 5 || k + 1 == 20) start_i = 1'b1;
            if (k + 1 == 33) begin
                start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd9;
            end
            @(negedge clk_i);
        end
        check("b2b_we_cnt",  we_cnt,    32'd2);
        check("b2b_first",   we_first,  32'd32);
        check("b2b_wd1",     wd_at_we,  32'd42);
        check("b2b_second",  we_second, 32'd65);
        check("b2b_wd2",     wd_second, 32'd14);
        check("b2b_busy",    busy_cnt,  32'd66);

        // Reset in the middle of CALC discards the result.
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        we_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (WE_o) we_cnt++;
            if (k + 1 == 10) reset_i = 1'b1;
            @(negedge clk_i);
        end
        reset_i = 1'b0;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_we",   {31'd0, WE_o},   32'd0);
        check("rst_wd",   wD_o,            32'd0);
        for (int k = 0; k < 40; k++) begin
            if (WE_o) we_cnt++;
            @(negedge clk_i);
        end
        check("rst_no_we", we_cnt, 32'd0);
        check("rst_wd_after", wD_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
